cond_unit: RTL and testbench

COND_UNIT -- requirements
Module: cond_unit

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/cond_check.sv | 44 ++++
 rtl/cond_unit.sv | 68 ++++++
 tb/tb_cond_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: condition codes and flag bit positions.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Used by the decoder and by cond_unit / cond_check so both sides agree
// on the encoding of the condition field and the {N,Z,C,V} flag layout.
package cpu_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Condition evaluator: decides whether an instruction executes from its cond field.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
// Ports: cond   - instruction condition field [31:28]
//        flags  - registered {N,Z,C,V}
//        cond_ex- 1 when the condition passes
module cond_check
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    cond_ex = 1'b1;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      // AL and the 1111 encoding both execute unconditionally.
      default: cond_ex = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution unit: gates decoder controls by the condition field, holds flags and event counters.
// Latency: gated controls are combinational (0 cycles); flag writes visible to cond_ex the next cycle.
// Backpressure: none; valid=0 marks a bubble and leaves all state untouched.
// Ports: clk, reset_n (async active-low); valid, cond, alu_flags, pcs, reg_w, mem_w,
//        flag_w, no_write from the decoder/ALU; pc_src, reg_write, mem_write, cond_ex,
//        flags, exec_cnt, squash_cnt out.
module cond_unit
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid,
  input  logic [3:0]  cond,
  input  logic [3:0]  alu_flags,
  input  logic        pcs,
  input  logic        reg_w,
  input  logic        mem_w,
  input  logic [1:0]  flag_w,
  input  logic        no_write,
  output logic        pc_src,
  output logic        reg_write,
  output logic        mem_write,
  output logic        cond_ex,
  output logic [3:0]  flags,
  output logic [15:0] exec_cnt,
  output logic [15:0] squash_cnt
);

  logic taken;
  logic squashed;

  // Evaluated against the registered flags, so an instruction never sees
  // the flags it is itself writing.
  cond_check u_cond_check (
    .cond    (cond),
    .flags   (flags),
    .cond_ex (cond_ex)
  );

  assign taken    = valid & cond_ex;
  assign squashed = valid & ~cond_ex;

  assign pc_src    = pcs   & taken;
  assign reg_write = reg_w & taken & ~no_write;
  assign mem_write = mem_w & taken;

  // N,Z and C,V are independently write-enabled so logical ops can leave C,V alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags <= 4'b0000;
    end else begin
      if (taken & flag_w[1]) flags[FLAG_N:FLAG_Z] <= alu_flags[FLAG_N:FLAG_Z];
      if (taken & flag_w[0]) flags[FLAG_C:FLAG_V] <= alu_flags[FLAG_C:FLAG_V];
    end
  end

  // Free-running 16-bit event counters; wrap naturally at 0xFFFF.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exec_cnt   <= 16'h0000;
      squash_cnt <= 16'h0000;
    end else begin
      if (taken)    exec_cnt   <= exec_cnt + 16'd1;
      if (squashed) squash_cnt <= squash_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_cond_unit.sv
module tb_cond_unit;

  logic        clk;
  logic        reset_n;
  logic        valid;
  logic [3:0]  cond;
  logic [3:0]  alu_flags;
  logic        pcs;
  logic        reg_w;
  logic        mem_w;
  logic [1:0]  flag_w;
  logic        no_write;
  logic        pc_src;
  logic        reg_write;
  logic        mem_write;
  logic        cond_ex;
  logic [3:0]  flags;
  logic [15:0] exec_cnt;
  logic [15:0] squash_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference state
  logic [3:0] m_flags;
  int         m_exec;
  int         m_squash;

  cond_unit dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .valid      (valid),
    .cond       (cond),
    .alu_flags  (alu_flags),
    .pcs        (pcs),
    .reg_w      (reg_w),
    .mem_w      (mem_w),
    .flag_w     (flag_w),
    .no_write   (no_write),
    .pc_src     (pc_src),
    .reg_write  (reg_write),
    .mem_write  (mem_write),
    .cond_ex    (cond_ex),
    .flags      (flags),
    .exec_cnt   (exec_cnt),
    .squash_cnt (squash_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pairs of conditions share a base predicate; the odd code is its negation.
  function automatic bit model_cond(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  // One instruction: drive at posedge+1, check comb outputs, clock, check state.
  task automatic step(input bit v, input logic [3:0] c, input logic [3:0] af,
                      input bit p, input bit rw, input bit mw,
                      input logic [1:0] fw, input bit nw, input bit do_chk);
    bit ce;
    valid = v; cond = c; alu_flags = af; pcs = p; reg_w = rw; mem_w = mw;
    flag_w = fw; no_write = nw;
    #1;
    ce = model_cond(c, m_flags);
    if (do_chk) begin
      chk("cond_ex",   cond_ex,   ce);
      chk("pc_src",    pc_src,    p && ce && v);
      chk("reg_write", reg_write, rw && ce && v && !nw);
      chk("mem_write", mem_write, mw && ce && v);
    end
    @(posedge clk);
    if (v && ce) begin
      if (fw[1]) m_flags[3:2] = af[3:2];
      if (fw[0]) m_flags[1:0] = af[1:0];
      m_exec = (m_exec + 1) % 65536;
    end
    if (v && !ce) m_squash = (m_squash + 1) % 65536;
    #1;
    if (do_chk) begin
      chk("flags",      flags,      m_flags);
      chk("exec_cnt",   exec_cnt,   m_exec);
      chk("squash_cnt", squash_cnt, m_squash);
    end
  endtask

  // Asynchronous reset pulse placed between clock edges; inputs idle on release.
  task automatic pulse_reset();
    #2;
    reset_n = 1'b0;
    #1;
    m_flags = 4'b0000; m_exec = 0; m_squash = 0;
    chk("rst_flags",  flags,      32'h0);
    chk("rst_exec",   exec_cnt,   32'h0);
    chk("rst_squash", squash_cnt, 32'h0);
    valid = 1'b1; pcs = 1'b1; cond = 4'h0;
    #1 chk("rst_eq_false", cond_ex, 32'h0);
    cond = 4'h1;
    #1 chk("rst_ne_true", cond_ex, 32'h1);
    cond = 4'hE;
    #1 chk("rst_pc_src_comb", pc_src, 32'h1);
    valid = 1'b0; pcs = 1'b0;
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rel_exec", exec_cnt, 32'h0);
  endtask

  initial begin
    reset_n = 1'b0; valid = 1'b0; cond = 4'h0; alu_flags = 4'h0;
    pcs = 1'b0; reg_w = 1'b0; mem_w = 1'b0; flag_w = 2'b00; no_write = 1'b0;
    m_flags = 4'b0000; m_exec = 0; m_squash = 0;
    #2;
    chk("reset_flags",  flags,      32'h0);
    chk("reset_exec",   exec_cnt,   32'h0);
    chk("reset_squash", squash_cnt, 32'h0);
    #10 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // AL with reg_w right after reset.
    step(1, 4'hE, 4'h0, 0, 1, 0, 2'b00, 0, 1);
    chk("al_exec_one", exec_cnt, 32'h1);

    // Compare then EQ consumer.
    step(1, 4'hE, 4'b0100, 0, 1, 0, 2'b11, 1, 1);
    chk("cmp_flags", flags, 32'h4);
    step(1, 4'h0, 4'h0, 0, 1, 0, 2'b00, 0, 1);

    // LT passing then failing.
    step(1, 4'hE, 4'b1000, 0, 0, 0, 2'b11, 1, 1);
    step(1, 4'hB, 4'h0, 0, 0, 1, 2'b00, 0, 1);
    step(1, 4'hE, 4'b1001, 0, 0, 0, 2'b11, 1, 1);
    step(1, 4'hB, 4'h0, 0, 0, 1, 2'b00, 0, 1);
    chk("lt_fail_squash", squash_cnt, 32'h1);

    // Independent flag-pair enables.
    step(1, 4'hE, 4'b0000, 0, 0, 0, 2'b11, 0, 1);
    step(1, 4'hE, 4'b1111, 0, 0, 0, 2'b01, 0, 1);
    chk("fw01_flags", flags, 32'h3);
    step(1, 4'hE, 4'b0000, 0, 0, 0, 2'b11, 0, 1);
    step(1, 4'hE, 4'b1111, 0, 0, 0, 2'b10, 0, 1);
    chk("fw10_flags", flags, 32'hC);
    // Flags are 1100: EQ passes, NE fails and must not write.
    step(1, 4'h1, 4'b0011, 0, 0, 0, 2'b11, 0, 1);
    chk("fail_hold_flags", flags, 32'hC);

    // Bubbles leave state alone and suppress outputs.
    step(0, 4'hE, 4'b1111, 1, 1, 1, 2'b11, 0, 1);
    chk("bubble_flags", flags, 32'hC);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(3, 0) != 0, 4'($urandom), 4'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
           1'($urandom), 1);
    end

    // Reset mid-run with flags forced to 1111 and counters nonzero.
    step(1, 4'hE, 4'b1111, 0, 0, 0, 2'b11, 0, 1);
    pulse_reset();

    // Counter wrap: 65535 AL instructions, then one more.
    for (int i = 0; i < 65535; i++) begin
      step(1, 4'hE, 4'h0, 0, 0, 0, 2'b00, 0, 0);
    end
    chk("exec_ffff", exec_cnt, 32'hFFFF);
    step(1, 4'hE, 4'h0, 0, 0, 0, 2'b00, 0, 1);
    chk("exec_wrap", exec_cnt, 32'h0);
    step(0, 4'hE, 4'h0, 1, 0, 0, 2'b00, 0, 1);
    chk("invalid_pc_src", pc_src, 32'h0);
    chk("invalid_exec",   exec_cnt, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
